// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared types and default sizing for the hazard/stall scheduler.
package hazard_sched_ctrl_pkg;

  localparam int REG_AW         = 3;
  localparam int DEF_NREG       = 8;
  localparam int DEF_PEND_W     = 2;
  localparam int DEF_BR_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UBR   = 2'd1,
    ST_CBR   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_sched_ctrl_scoreboard.sv
// In-flight write scoreboard: per-register and SP pending counters plus the
// hazard compare against post-writeback counts.
module hazard_scoreboard
  import hazard_sched_ctrl_pkg::*;
#(
  parameter int NREG   = DEF_NREG,
  parameter int PEND_W = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_use,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_use,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_sp_use,
  input  logic              id_sp_wr,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_sp,
  output logic              hazard
);

  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q    [NREG];
  logic [PEND_W-1:0] pend_d    [NREG];
  logic [PEND_W-1:0] pend_post [NREG];
  logic [PEND_W-1:0] sp_pend_q;
  logic [PEND_W-1:0] sp_pend_d;
  logic [PEND_W-1:0] sp_post;

  // Retire first, then allocate, so a same-cycle pair on one register cancels.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_post[r] = pend_q[r];
      if (wb_valid && (wb_rd == REG_AW'(r)) && (pend_q[r] != '0)) begin
        pend_post[r] = pend_q[r] - PEND_ONE;
      end
      pend_d[r] = pend_post[r];
      if (issue && id_wr && (id_rd == REG_AW'(r))) begin
        pend_d[r] = pend_post[r] + PEND_ONE;
      end
    end
  end

  always_comb begin
    sp_post = sp_pend_q;
    if (wb_sp && (sp_pend_q != '0)) begin
      sp_post = sp_pend_q - PEND_ONE;
    end
    sp_pend_d = sp_post;
    if (issue && id_sp_wr) begin
      sp_pend_d = sp_post + PEND_ONE;
    end
  end

  // The max checks keep an issuing writer from wrapping its counter.
  always_comb begin
    hazard = 1'b0;
    if (id_rs1_use && (pend_post[id_rs1] != '0)) hazard = 1'b1;
    if (id_rs2_use && (pend_post[id_rs2] != '0)) hazard = 1'b1;
    if (id_sp_use  && (sp_post != '0))           hazard = 1'b1;
    if (id_wr      && (pend_post[id_rd] == PEND_MAX)) hazard = 1'b1;
    if (id_sp_wr   && (sp_post == PEND_MAX))     hazard = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
      sp_pend_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= pend_d[r];
      end
      sp_pend_q <= sp_pend_d;
    end
  end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Decode-stage issue/bubble scheduler with branch-hold FSM.
// Optional perf counters (stall_cycles, branch_cycles) under HAZARD_PERF_CNT_EN.
//
// state | meaning
// IDLE  | normal issue; stalls on scoreboard hazard
// UBR   | one-cycle fetch hold after an unconditional branch
// CBR   | fetch held waiting for conditional-branch resolution
// FLUSH | one-cycle discard of the wrong-path fetch after a taken branch
module hazard_sched_ctrl
  import hazard_sched_ctrl_pkg::*;
#(
  parameter int NREG       = DEF_NREG,
  parameter int PEND_W     = DEF_PEND_W,
  parameter int BR_TIMEOUT = DEF_BR_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_rs1_use,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs2_use,
  input  logic              id_wr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_sp_use,
  input  logic              id_sp_wr,
  input  logic              id_branch,
  input  logic              id_cbranch,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_sp,
  input  logic              br_resolve,
  input  logic              br_taken,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]       stall_cycles,
  output logic [15:0]       branch_cycles,
`endif
  output logic              issue,
  output logic              bubble,
  output logic              hold_fetch,
  output logic              flush,
  output logic              br_timeout
);

  localparam int CNT_W = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             hold_raw, flush_raw, tmo_raw;
  logic             idle;

  hazard_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .id_rs1     (id_rs1),
    .id_rs1_use (id_rs1_use),
    .id_rs2     (id_rs2),
    .id_rs2_use (id_rs2_use),
    .id_wr      (id_wr),
    .id_rd      (id_rd),
    .id_sp_use  (id_sp_use),
    .id_sp_wr   (id_sp_wr),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_sp      (wb_sp),
    .hazard     (hazard)
  );

  assign idle = (state_q == ST_IDLE);

  // rst_n gating forces every output low for the whole reset assertion.
  assign issue      = rst_n & id_valid & ~hazard & idle;
  assign bubble     = rst_n & ((id_valid & ~issue) | ~idle);
  assign hold_fetch = rst_n & hold_raw;
  assign flush      = rst_n & flush_raw;
  assign br_timeout = rst_n & tmo_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_raw  = 1'b0;
    flush_raw = 1'b0;
    tmo_raw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_raw = id_valid & hazard;
        if (issue && id_cbranch) begin
          state_d = ST_CBR;
          cnt_d   = '0;
        end else if (issue && id_branch) begin
          state_d = ST_UBR;
        end
      end
      ST_UBR: begin
        hold_raw = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_CBR: begin
        hold_raw = 1'b1;
        // A resolve landing on the last wait cycle beats the timeout.
        if (br_resolve) begin
          state_d = br_taken ? ST_FLUSH : ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          tmo_raw = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        hold_raw  = 1'b1;
        flush_raw = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (id_valid && hazard && idle && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (!idle && (branch_cnt_q != 16'hFFFF)) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign stall_cycles  = stall_cnt_q;
  assign branch_cycles = branch_cnt_q;
`endif

endmodule
